// File: rtl/h6_mul_sequencer.sv
// rtl/h6_mul_sequencer.sv - control sequencer driving the H6 multiplier wrapper strobes and S-bus readout
module h6_mul_sequencer #(
    parameter int ITER      = 16,
    parameter int LOAD_HOLD = 2
) (
    input  logic       CLK_50,
    input  logic       Rst,
    input  logic       start,
    input  logic       b_src,
    input  logic [1:0] read_mode,
    input  logic       result_ready,
    output logic       busy,
    output logic       done,
    output logic       MUL1,
    output logic       MUL2_1,
    output logic       MUL2_2,
    output logic       h6_rst,
    output logic       inQLK,
    output logic       inTWO,
    output logic       inTHREE,
    output logic       inFOUR,
    output logic       ALS_H6_a,
    output logic       ALS_H6_q,
    output logic       result_valid,
    output logic       result_part
);

    typedef enum logic [3:0] {
        IDLE, CLR, LD_A, LD_B, MUL, FIN, OUT_A, OUT_Q, DONE
    } state_t;

    localparam int CW = 8;
    localparam logic [CW-1:0] LD_LAST  = CW'(LOAD_HOLD - 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(2 * ITER - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          b_src_q;
    logic [1:0]    mode_q;
    logic          ld_last;
    logic          mul_last;

    assign ld_last  = (cnt == LD_LAST);
    assign mul_last = (cnt == MUL_LAST);

    // Mode 11 is folded into 00 at capture so the rest of the FSM sees three modes only.
    always_ff @(posedge CLK_50) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            b_src_q <= 1'b0;
            mode_q  <= 2'b00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                b_src_q <= b_src;
                mode_q  <= (read_mode == 2'b11) ? 2'b00 : read_mode;
            end
            case (state)
                LD_A, LD_B: cnt <= ld_last  ? '0 : cnt + CW'(1);
                MUL:        cnt <= mul_last ? '0 : cnt + CW'(1);
                default:    cnt <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLR;
            CLR:     state_nxt = LD_A;
            LD_A:    if (ld_last) state_nxt = LD_B;
            LD_B:    if (ld_last) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = FIN;
            FIN:     state_nxt = (mode_q == 2'b01) ? OUT_Q : OUT_A;
            OUT_A:   if (result_ready) state_nxt = (mode_q == 2'b10) ? DONE : OUT_Q;
            OUT_Q:   if (result_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Step strobe fires on even step indices, giving ITER pulses over 2*ITER cycles.
    always_comb begin
        busy         = (state != IDLE);
        done         = 1'b0;
        MUL1         = 1'b0;
        MUL2_1       = 1'b0;
        MUL2_2       = 1'b0;
        inQLK        = 1'b0;
        inTWO        = 1'b0;
        inTHREE      = 1'b0;
        inFOUR       = 1'b0;
        ALS_H6_a     = 1'b0;
        ALS_H6_q     = 1'b0;
        result_valid = 1'b0;
        result_part  = 1'b0;
        case (state)
            LD_A: begin
                MUL1  = 1'b1;
                inTWO = ld_last;
            end
            LD_B: begin
                MUL2_1  = ~b_src_q;
                MUL2_2  = b_src_q;
                inTHREE = ld_last;
            end
            MUL:  inQLK = ~cnt[0];
            FIN:  inFOUR = 1'b1;
            OUT_A: begin
                ALS_H6_a     = 1'b1;
                result_valid = 1'b1;
            end
            OUT_Q: begin
                ALS_H6_q     = 1'b1;
                result_valid = 1'b1;
                result_part  = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign h6_rst = Rst | (state == CLR);

endmodule

// File: tb/tb_h6_mul_sequencer.sv
// tb/tb_h6_mul_sequencer.sv - directed bench for h6_mul_sequencer at default and minimum parameters
module tb_h6_mul_sequencer;

    logic       CLK_50 = 1'b0;
    logic       Rst = 1'b1;
    logic       start = 1'b0, b_src = 1'b0, result_ready = 1'b1;
    logic [1:0] read_mode = 2'b00;
    logic       start2 = 1'b0, b_src2 = 1'b0, result_ready2 = 1'b1;
    logic [1:0] read_mode2 = 2'b00;

    logic busy, done, MUL1, MUL2_1, MUL2_2, h6_rst, inQLK, inTWO, inTHREE, inFOUR;
    logic ALS_H6_a, ALS_H6_q, result_valid, result_part;
    logic busy2, done2, MUL1_2, MUL2_1_2, MUL2_2_2, h6_rst2, inQLK2, inTWO2, inTHREE2, inFOUR2;
    logic ALS_H6_a2, ALS_H6_q2, result_valid2, result_part2;

    int total = 0;
    int bad = 0;

    always #5 CLK_50 = ~CLK_50;

    h6_mul_sequencer #(.ITER(16), .LOAD_HOLD(2)) dut (
        .CLK_50(CLK_50), .Rst(Rst), .start(start), .b_src(b_src), .read_mode(read_mode),
        .result_ready(result_ready), .busy(busy), .done(done), .MUL1(MUL1), .MUL2_1(MUL2_1),
        .MUL2_2(MUL2_2), .h6_rst(h6_rst), .inQLK(inQLK), .inTWO(inTWO), .inTHREE(inTHREE),
        .inFOUR(inFOUR), .ALS_H6_a(ALS_H6_a), .ALS_H6_q(ALS_H6_q),
        .result_valid(result_valid), .result_part(result_part)
    );

    h6_mul_sequencer #(.ITER(1), .LOAD_HOLD(1)) dut_min (
        .CLK_50(CLK_50), .Rst(Rst), .start(start2), .b_src(b_src2), .read_mode(read_mode2),
        .result_ready(result_ready2), .busy(busy2), .done(done2), .MUL1(MUL1_2), .MUL2_1(MUL2_1_2),
        .MUL2_2(MUL2_2_2), .h6_rst(h6_rst2), .inQLK(inQLK2), .inTWO(inTWO2), .inTHREE(inTHREE2),
        .inFOUR(inFOUR2), .ALS_H6_a(ALS_H6_a2), .ALS_H6_q(ALS_H6_q2),
        .result_valid(result_valid2), .result_part(result_part2)
    );

    // {busy,done,MUL1,MUL2_1,MUL2_2,h6_rst,inQLK,inTWO,inTHREE,inFOUR,ALS_a,ALS_q,valid,part}
    wire [13:0] o1 = {busy, done, MUL1, MUL2_1, MUL2_2, h6_rst, inQLK, inTWO, inTHREE, inFOUR,
                      ALS_H6_a, ALS_H6_q, result_valid, result_part};
    wire [13:0] o2 = {busy2, done2, MUL1_2, MUL2_1_2, MUL2_2_2, h6_rst2, inQLK2, inTWO2, inTHREE2,
                      inFOUR2, ALS_H6_a2, ALS_H6_q2, result_valid2, result_part2};

    // Expected outputs c cycles after the start-accept edge, with result_ready held high.
    function automatic logic [13:0] exp_tl(int c, int it, int lh, bit bs, bit [1:0] md);
        logic [13:0] e;
        int fin, oa, dn;
        bit has_a, has_q;
        e     = '0;
        fin   = 2 * lh + 2 * it + 1;
        oa    = fin + 1;
        has_a = (md != 2'b01);
        has_q = (md != 2'b10);
        dn    = oa + int'(has_a) + int'(has_q);
        if (c == 0) begin
            e[13] = 1'b1; e[8] = 1'b1;
        end else if (c <= lh) begin
            e[13] = 1'b1; e[11] = 1'b1; e[6] = (c == lh);
        end else if (c <= 2 * lh) begin
            e[13] = 1'b1; e[10] = ~bs; e[9] = bs; e[5] = (c == 2 * lh);
        end else if (c < fin) begin
            e[13] = 1'b1; e[7] = (((c - 2 * lh - 1) % 2) == 0);
        end else if (c == fin) begin
            e[13] = 1'b1; e[4] = 1'b1;
        end else if (c < dn) begin
            e[13] = 1'b1; e[1] = 1'b1;
            if (has_a && c == oa) e[3] = 1'b1;
            else begin e[2] = 1'b1; e[0] = 1'b1; end
        end else if (c == dn) begin
            e[13] = 1'b1; e[12] = 1'b1;
        end
        return e;
    endfunction

    task automatic begin_run(bit bs, bit [1:0] md);
        @(negedge CLK_50);
        start = 1'b1; b_src = bs; read_mode = md;
        @(negedge CLK_50);
        start = 1'b0;
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        repeat (3) @(negedge CLK_50);
        total++;
        if (o1 !== 14'h0100) begin bad++; $display("FAIL reset_hold dut got=%h exp=%h", o1, 14'h0100); end
        total++;
        if (o2 !== 14'h0100) begin bad++; $display("FAIL reset_hold dut_min got=%h exp=%h", o2, 14'h0100); end
        Rst = 1'b0;
        @(negedge CLK_50);
        total++;
        if (o1 !== 14'h0000) begin bad++; $display("FAIL reset_release dut got=%h exp=0", o1); end
        total++;
        if (o2 !== 14'h0000) begin bad++; $display("FAIL reset_release dut_min got=%h exp=0", o2); end
    endtask

    task automatic test_basic;
        int qlk, four;
        qlk = 0; four = 0;
        result_ready = 1'b1;
        begin_run(1'b0, 2'b00);
        for (int c = 0; c <= 45; c++) begin
            total++;
            if (o1 !== exp_tl(c, 16, 2, 1'b0, 2'b00)) begin
                bad++; $display("FAIL basic c=%0d got=%h exp=%h", c, o1, exp_tl(c, 16, 2, 1'b0, 2'b00));
            end
            qlk += int'(inQLK); four += int'(inFOUR);
            @(negedge CLK_50);
        end
        total++;
        if (qlk != 16) begin bad++; $display("FAIL basic_qlk_count got=%0d exp=16", qlk); end
        total++;
        if (four != 1) begin bad++; $display("FAIL basic_four_count got=%0d exp=1", four); end
    endtask

    task automatic test_bsrc1;
        int m21, m22;
        m21 = 0; m22 = 0;
        begin_run(1'b1, 2'b00);
        for (int c = 0; c <= 45; c++) begin
            total++;
            if (o1 !== exp_tl(c, 16, 2, 1'b1, 2'b00)) begin
                bad++; $display("FAIL bsrc1 c=%0d got=%h exp=%h", c, o1, exp_tl(c, 16, 2, 1'b1, 2'b00));
            end
            m21 += int'(MUL2_1); m22 += int'(MUL2_2);
            @(negedge CLK_50);
        end
        total++;
        if (m21 != 0) begin bad++; $display("FAIL bsrc1_mul2_1 got=%0d exp=0", m21); end
        total++;
        if (m22 != 2) begin bad++; $display("FAIL bsrc1_mul2_2 got=%0d exp=2", m22); end
    endtask

    task automatic test_q_only_stall;
        int a_seen, vcnt;
        logic [13:0] e;
        a_seen = 0; vcnt = 0;
        result_ready = 1'b0;
        begin_run(1'b0, 2'b01);
        for (int c = 0; c <= 46; c++) begin
            if (c < 38)       e = exp_tl(c, 16, 2, 1'b0, 2'b01);
            else if (c <= 43) e = 14'h2007;
            else if (c == 44) e = 14'h3000;
            else              e = 14'h0000;
            total++;
            if (o1 !== e) begin bad++; $display("FAIL q_only c=%0d got=%h exp=%h", c, o1, e); end
            a_seen += int'(ALS_H6_a); vcnt += int'(result_valid);
            result_ready = (c >= 43);
            @(negedge CLK_50);
        end
        result_ready = 1'b1;
        total++;
        if (a_seen != 0) begin bad++; $display("FAIL q_only_als_a got=%0d exp=0", a_seen); end
        total++;
        if (vcnt != 6) begin bad++; $display("FAIL q_only_valid_cycles got=%0d exp=6", vcnt); end
    endtask

    task automatic test_rst_mid_mul;
        int qlk;
        qlk = 0;
        result_ready = 1'b1;
        begin_run(1'b0, 2'b00);
        for (int c = 0; c <= 12; c++) begin
            total++;
            if (o1 !== exp_tl(c, 16, 2, 1'b0, 2'b00)) begin
                bad++; $display("FAIL rst_mul_pre c=%0d got=%h exp=%h", c, o1, exp_tl(c, 16, 2, 1'b0, 2'b00));
            end
            qlk += int'(inQLK);
            if (c < 12) @(negedge CLK_50);
        end
        Rst = 1'b1;
        #1;
        total++;
        if (h6_rst !== 1'b1) begin bad++; $display("FAIL rst_mul_h6_comb got=%b exp=1", h6_rst); end
        @(negedge CLK_50);
        total++;
        if (o1 !== 14'h0100) begin bad++; $display("FAIL rst_mul_idle got=%h exp=%h", o1, 14'h0100); end
        Rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK_50);
            total++;
            if (o1 !== 14'h0000) begin bad++; $display("FAIL rst_mul_quiet c=%0d got=%h exp=0", c, o1); end
        end
        total++;
        if (qlk != 4) begin bad++; $display("FAIL rst_mul_qlk_before got=%0d exp=4", qlk); end
        begin_run(1'b0, 2'b00);
        for (int c = 0; c <= 42; c++) begin
            total++;
            if (o1 !== exp_tl(c, 16, 2, 1'b0, 2'b00)) begin
                bad++; $display("FAIL rst_mul_rerun c=%0d got=%h exp=%h", c, o1, exp_tl(c, 16, 2, 1'b0, 2'b00));
            end
            @(negedge CLK_50);
        end
    endtask

    task automatic test_rst_in_out;
        result_ready = 1'b0;
        begin_run(1'b0, 2'b01);
        repeat (40) @(negedge CLK_50);
        total++;
        if (result_valid !== 1'b1) begin bad++; $display("FAIL rst_out_valid_before got=%b exp=1", result_valid); end
        Rst = 1'b1;
        @(negedge CLK_50);
        total++;
        if (o1 !== 14'h0100) begin bad++; $display("FAIL rst_out_drop got=%h exp=%h", o1, 14'h0100); end
        Rst = 1'b0;
        result_ready = 1'b1;
        @(negedge CLK_50);
        total++;
        if (o1 !== 14'h0000) begin bad++; $display("FAIL rst_out_idle got=%h exp=0", o1); end
    endtask

    task automatic test_start_while_busy;
        int dcnt;
        dcnt = 0;
        result_ready = 1'b1;
        begin_run(1'b0, 2'b00);
        for (int c = 0; c <= 60; c++) begin
            total++;
            if (o1 !== exp_tl(c, 16, 2, 1'b0, 2'b00)) begin
                bad++; $display("FAIL busy_start c=%0d got=%h exp=%h", c, o1, exp_tl(c, 16, 2, 1'b0, 2'b00));
            end
            dcnt += int'(done);
            start = (c == 3 || c == 38);
            @(negedge CLK_50);
        end
        total++;
        if (dcnt != 1) begin bad++; $display("FAIL busy_start_done_count got=%0d exp=1", dcnt); end
    endtask

    task automatic test_min_params;
        int qlk, vfirst, dcnt, qseen;
        qlk = 0; vfirst = -1; dcnt = 0; qseen = 0;
        result_ready2 = 1'b1;
        @(negedge CLK_50);
        start2 = 1'b1; read_mode2 = 2'b10; b_src2 = 1'b0;
        @(negedge CLK_50);
        start2 = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            total++;
            if (o2 !== exp_tl(c, 1, 1, 1'b0, 2'b10)) begin
                bad++; $display("FAIL min c=%0d got=%h exp=%h", c, o2, exp_tl(c, 1, 1, 1'b0, 2'b10));
            end
            qlk += int'(inQLK2); dcnt += int'(done2); qseen += int'(ALS_H6_q2);
            if (result_valid2 && vfirst < 0) vfirst = c;
            @(negedge CLK_50);
        end
        total++;
        if (qlk != 1) begin bad++; $display("FAIL min_qlk got=%0d exp=1", qlk); end
        total++;
        if (vfirst != 6) begin bad++; $display("FAIL min_first_valid got=%0d exp=6", vfirst); end
        total++;
        if (dcnt != 1) begin bad++; $display("FAIL min_done got=%0d exp=1", dcnt); end
        total++;
        if (qseen != 0) begin bad++; $display("FAIL min_q_word got=%0d exp=0", qseen); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bsrc1;
        test_q_only_stall;
        test_rst_mid_mul;
        test_rst_in_out;
        test_start_while_busy;
        test_min_params;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/h6_mul_sequencer.md
Name: h6_mul_sequencer

Overview:
- Control FSM directly upstream of the H6 multiplier wrapper.
- On a start request it produces the wrapper's full control sequence:
  - clears H6;
  - gates the A bus, then the B bus, into H6 and latches each operand;
  - clocks ITER multiply steps and finalises.
- It then places the A-register and/or Q-register result on the S-bus with a valid/ready handshake.
- The datapath buses are not touched here; this block only drives the wrapper's enable and strobe inputs.

Parameters:
- ITER, 16, number of multiply step pulses on inQLK (legal 1..64).
- LOAD_HOLD, 2, cycles each operand bus gate is held open (legal 1..8).

Ports:
- CLK_50  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- b_src  input  1  B operand source, sampled with start: 0 selects MUL2_1, 1 selects MUL2_2.
- read_mode  input  2  sampled with start: 00 = A then Q, 01 = Q only, 10 = A only, 11 = treated as 00.
- result_ready  input  1  S-bus consumer accepts the current result word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last result word is accepted.
- MUL1  output  1  A-bus gate enable to the wrapper.
- MUL2_1  output  1  B-bus gate enable, path 1.
- MUL2_2  output  1  B-bus gate enable, path 2.
- h6_rst  output  1  H6 reset; equals Rst OR (state == CLR).
- inQLK  output  1  multiply step strobe.
- inTWO  output  1  multiplicand latch strobe.
- inTHREE  output  1  multiplier latch strobe.
- inFOUR  output  1  finalise strobe.
- ALS_H6_a  output  1  A-register to S-bus enable.
- ALS_H6_q  output  1  Q-register to S-bus enable.
- result_valid  output  1  a result word is on the S-bus.
- result_part  output  1  0 = A word, 1 = Q word; meaningful only while result_valid is high.

Behaviour:
- Reset
  - Rst high at any edge, including mid-operation: next state IDLE, all counters cleared.
  - All outputs 0 except h6_rst, which is high for as long as Rst is high.
  - A held result_valid drops on the edge after Rst.
- Output timing
  - Every output except h6_rst is a Moore decode of the registered state and counters.
  - No output depends combinationally on start or result_ready.
- States
  - IDLE: start = 1 latches b_src and read_mode, then goes to CLR. Otherwise stays in IDLE.
  - CLR: 1 cycle; h6_rst = 1. Goes to LD_A.
  - LD_A: LOAD_HOLD cycles with MUL1 = 1; inTWO = 1 on the last of those cycles only. Goes to LD_B.
  - LD_B: LOAD_HOLD cycles with MUL2_1 = ~b_src and MUL2_2 = b_src; inTHREE = 1 on the last cycle only. Goes to MUL.
  - MUL: 2*ITER cycles. inQLK = 1 on even cycle indices (0, 2, …) and 0 on odd ones, giving exactly ITER pulses. The step counter wraps to 0 on exit. Goes to FIN.
  - FIN: 1 cycle; inFOUR = 1. Goes to OUT_A if read_mode ∈ {00, 10, 11}, else to OUT_Q.
  - OUT_A: ALS_H6_a = 1, result_valid = 1, result_part = 0. Holds until result_ready = 1, then goes to OUT_Q (modes 00/11) or DONE (mode 10).
  - OUT_Q: ALS_H6_q = 1, result_valid = 1, result_part = 1. Holds until result_ready = 1, then goes to DONE.
  - DONE: 1 cycle; done = 1, busy = 1. Goes to IDLE.
- Exclusivity
  - MUL1, MUL2_1 and MUL2_2 are mutually exclusive.
  - ALS_H6_a and ALS_H6_q are mutually exclusive.
- Latency
  - With defaults, first result_valid comes 1+2+2+32+1 = 38 cycles after the start-accept edge.
  - In general: 2 + 2*LOAD_HOLD + 2*ITER cycles.
- Handshake
  - A word transfers on any edge where result_valid and result_ready are both 1.
  - result_ready already high on entry to an OUT state gives a 1-cycle word.
  - result_ready while result_valid = 0 is ignored.
- start while busy is ignored; there is no queueing.
- Rst and start high in the same cycle: Rst wins, stay in IDLE.

Test Plan:
- Defaults, read_mode = 00, b_src = 0, result_ready tied to 1:
  - MUL1 high 2 cycles then MUL2_1 high 2 cycles, with inTWO/inTHREE each a single pulse on the second cycle.
  - Exactly 16 inQLK pulses, then one inFOUR.
  - ALS_H6_a at cycle 38, ALS_H6_q at 39, done at 40.
- b_src = 1: MUL2_2 high for 2 cycles, MUL2_1 never asserts during the run.
- read_mode = 01:
  - ALS_H6_a never asserts.
  - With result_ready held low 5 cycles, ALS_H6_q and result_valid stay high 5+1 cycles.
  - done follows the acceptance edge by 1 cycle.
- Rst asserted at MUL step 7:
  - Next cycle IDLE, all outputs 0, no further inQLK.
  - A new start reruns the full 38-cycle prologue.
- start pulsed during LD_B and during OUT_A: sequence unchanged, exactly one done.
- ITER = 1, LOAD_HOLD = 1, read_mode = 10: one inQLK, result_valid at cycle 6, done after the A word only.
